memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM stage of the 5-stage RV64 pipeline; consumes execute outputs, feeds writeback.
//  Performs data-memory loads/stores over a req/ack bus with sign/zero extension.
//  Resolves BEQ (branch & zero) into a PC redirect. Stalls upstream while an access is pending.
// PARAMETERS
//  XLEN         64   data/address width
//  TIMEOUT_CYC  16   max WAIT cycles before bus error (>=1)
// PORTS
//  i_clk            in   1     clock
//  i_rst_n          in   1     async active-low reset
//  i_valid          in   1     execute outputs carry a real instruction
//  i_instruction    in   32    instr; funct3=[14:12], rd=[11:7]
//  i_pc             in   XLEN  instr PC (passed through)
//  i_alu_result     in   XLEN  effective address, or result for non-mem ops
//  i_alu_zero       in   1     ALU zero flag
//  i_jmp_addr       in   XLEN  branch target
//  i_rs2_value      in   XLEN  store data
//  i_branch, i_mem_write, i_mem_read, i_mem_to_reg, i_reg_write  in 1 each  control
//  o_stall          out  1     upstream must hold its outputs this cycle
//  o_dmem_req       out  1     bus request
//  o_dmem_we        out  1     1=store
//  o_dmem_addr      out  XLEN  doubleword-aligned address ({addr[63:3],3'b0})
//  o_dmem_wdata     out  XLEN  store data shifted to byte lane
//  o_dmem_wstrb     out  8     byte enables
//  i_dmem_ack       in   1     request complete; rdata valid same cycle
//  i_dmem_rdata     in   XLEN  aligned doubleword read data
//  o_pc_src         out  1     1-cycle redirect pulse
//  o_branch_target  out  XLEN  target, valid with o_pc_src
//  o_valid          out  1     writeback outputs valid
//  o_instruction    out  32    to WB
//  o_pc             out  XLEN  to WB
//  o_alu_result     out  XLEN  to WB
//  o_mem_data       out  XLEN  extended load data
//  o_rd             out  5     destination register
//  o_mem_to_reg     out  1     to WB
//  o_reg_write      out  1     to WB (0 on fault)
//  o_fault          out  1     1-cycle pulse: misaligned access or bus timeout
// BEHAVIOUR
//  Reset (async, i_rst_n=0): every output 0, FSM=IDLE, timeout counter 0; any pending req dropped.
//  FSM IDLE: mem op = i_valid&(i_mem_read|i_mem_write).
//   - non-mem op: registered to WB outputs next posedge (latency 1); o_stall=0.
//   - mem op, aligned: o_stall=1 comb; posedge latches addr/data/ctrl, o_dmem_req=1 -> WAIT.
//   - misaligned (H:addr[0]!=0, W:addr[1:0]!=0, D:addr[2:0]!=0): no bus access; next cycle
//     o_valid=1, o_reg_write=0, o_fault=1.
//  FSM WAIT: req/we/addr/wdata/wstrb held stable; inputs ignored; o_stall=1 until ack.
//   - i_dmem_ack=1: o_stall=0 that cycle; posedge drops req, registers WB outputs -> IDLE.
//     Ack and a new upstream mem op in the same cycle: new op starts from IDLE next cycle.
//   - counter reaches TIMEOUT_CYC without ack: drop req, o_valid=1, o_reg_write=0,
//     o_fault=1 -> IDLE. Ack outside WAIT is ignored.
//  Width by funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
//   lane = addr[2:0]; wstrb = size mask << lane; wdata = rs2 << 8*lane.
//   load: rdata >> 8*lane, then sign-extend (000-010) or zero-extend (100-110); LD raw.
//   funct3=111 treated as fault (no access).
//  Stall bubbles: while o_stall=1, o_valid=0 and o_reg_write=0 (WB sees no instruction).
//  Branch: o_pc_src <= i_valid&i_branch&i_alu_zero, o_branch_target <= i_jmp_addr, one cycle,
//   registered like other non-mem outputs; never asserted together with a mem op.
//  o_rd = instruction[11:7]; o_mem_data=0 for non-loads.
// TESTING
//  ADD result 0x5, reg_write=1 -> next cycle o_valid=1, o_alu_result=0x5, o_stall never high.
//  LB addr 0x1003, rdata byte3=0x80, ack after 3 cycles -> o_stall 4 cycles, o_mem_data=0xFFFF_FFFF_FFFF_FF80.
//  SH addr 0x2006, rs2=0xBEEF -> dmem_addr=0x2000, wstrb=0xC0, wdata=0xBEEF<<48, we=1.
//  LW addr 0x1002 -> no req, o_fault=1, o_reg_write=0, no stall.
//  LD with ack never raised -> req drops after TIMEOUT_CYC cycles, o_fault pulse, FSM IDLE.
//  BEQ zero=1 target 0x400 -> o_pc_src pulse 1 cycle, o_branch_target=0x400; rst_n low in WAIT -> req=0 immediately.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: RV64 MEM stage with req/ack data bus, load extension and BEQ redirect
module memory_stage #(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_alu_zero,
  input  logic [XLEN-1:0] i_jmp_addr,
  input  logic [XLEN-1:0] i_rs2_value,
  input  logic            i_branch,
  input  logic            i_mem_write,
  input  logic            i_mem_read,
  input  logic            i_mem_to_reg,
  input  logic            i_reg_write,
  output logic            o_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [7:0]      o_dmem_wstrb,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_pc_src,
  output logic [XLEN-1:0] o_branch_target,
  output logic            o_valid,
  output logic [31:0]     o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_mem_data,
  output logic [4:0]      o_rd,
  output logic            o_mem_to_reg,
  output logic            o_reg_write,
  output logic            o_fault
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]      wstrb_q, wstrb_d;
  logic [31:0]     lat_instr_q, lat_instr_d;
  logic [XLEN-1:0] lat_pc_q, lat_pc_d, lat_addr_q, lat_addr_d;
  logic            lat_m2r_q, lat_m2r_d, lat_rw_q, lat_rw_d, lat_ld_q, lat_ld_d;
  logic            valid_q, valid_d, rw_q, rw_d, m2r_q, m2r_d;
  logic            fault_q, fault_d, pc_src_q, pc_src_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d, alu_q, alu_d, mem_data_q, mem_data_d, target_q, target_d;
  logic [2:0]      f3, lane, lf3;
  logic [7:0]      mask;
  logic            is_mem, misal, tmo, done, stall;
  logic [XLEN-1:0] sh, ext;
  assign f3     = i_instruction[14:12];
  assign lane   = i_alu_result[2:0];
  assign is_mem = i_valid & (i_mem_read | i_mem_write);
  // funct3=111 has no access width, so it is rejected like a misaligned access
  assign misal  = (f3 == 3'b111) | ((f3[1:0] == 2'd1) & lane[0]) |
                  ((f3[1:0] == 2'd2) & (|lane[1:0])) | ((f3[1:0] == 2'd3) & (|lane));
  assign mask   = (f3[1:0] == 2'd0) ? 8'h01 : (f3[1:0] == 2'd1) ? 8'h03 :
                  (f3[1:0] == 2'd2) ? 8'h0F : 8'hFF;
  assign lf3    = lat_instr_q[14:12];
  assign sh     = i_dmem_rdata >> {lat_addr_q[2:0], 3'b000};
  assign ext    = (lf3 == 3'b000) ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
                  (lf3 == 3'b001) ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
                  (lf3 == 3'b010) ? {{(XLEN-32){sh[31]}}, sh[31:0]} :
                  (lf3 == 3'b100) ? {{(XLEN-8){1'b0}}, sh[7:0]} :
                  (lf3 == 3'b101) ? {{(XLEN-16){1'b0}}, sh[15:0]} :
                  (lf3 == 3'b110) ? {{(XLEN-32){1'b0}}, sh[31:0]} : sh;
  assign tmo    = cnt_q == CW'(TIMEOUT_CYC - 1);
  assign done   = i_dmem_ack | tmo;
  // Next state: launch aligned accesses, retire non-mem/faulting ops, finish on ack or timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    lat_instr_d = lat_instr_q;
    lat_pc_d    = lat_pc_q;
    lat_addr_d  = lat_addr_q;
    lat_m2r_d   = lat_m2r_q;
    lat_rw_d    = lat_rw_q;
    lat_ld_d    = lat_ld_q;
    valid_d     = 1'b0;
    rw_d        = 1'b0;
    fault_d     = 1'b0;
    pc_src_d    = 1'b0;
    mem_data_d  = '0;
    m2r_d       = m2r_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    target_d    = target_q;
    stall       = 1'b0;
    if (state_q == S_IDLE) begin
      if (is_mem & ~misal) begin
        stall       = 1'b1;
        state_d     = S_WAIT;
        cnt_d       = '0;
        req_d       = 1'b1;
        we_d        = i_mem_write;
        addr_d      = {i_alu_result[XLEN-1:3], 3'b000};
        wdata_d     = i_rs2_value << {lane, 3'b000};
        wstrb_d     = mask << lane;
        lat_instr_d = i_instruction;
        lat_pc_d    = i_pc;
        lat_addr_d  = i_alu_result;
        lat_m2r_d   = i_mem_to_reg;
        lat_rw_d    = i_reg_write;
        lat_ld_d    = i_mem_read;
      end else begin
        valid_d  = i_valid;
        rw_d     = i_valid & i_reg_write & ~is_mem;
        fault_d  = is_mem;
        pc_src_d = i_valid & i_branch & i_alu_zero & ~is_mem;
        target_d = i_jmp_addr;
        m2r_d    = i_mem_to_reg;
        instr_d  = i_instruction;
        pc_d     = i_pc;
        alu_d    = i_alu_result;
      end
    end else begin
      stall = ~done;
      cnt_d = done ? '0 : cnt_q + 1'b1;
      if (done) begin
        state_d    = S_IDLE;
        req_d      = 1'b0;
        valid_d    = 1'b1;
        rw_d       = i_dmem_ack & lat_rw_q;
        fault_d    = ~i_dmem_ack;
        mem_data_d = (i_dmem_ack & lat_ld_q) ? ext : '0;
        m2r_d      = lat_m2r_q;
        instr_d    = lat_instr_q;
        pc_d       = lat_pc_q;
        alu_d      = lat_addr_q;
      end
    end
  end
  // State, bus and writeback registers; reset clears everything and drops any pending request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lat_instr_q <= '0;
      lat_pc_q    <= '0;
      lat_addr_q  <= '0;
      lat_m2r_q   <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_ld_q    <= 1'b0;
      valid_q     <= 1'b0;
      rw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      fault_q     <= 1'b0;
      pc_src_q    <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      mem_data_q  <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      lat_instr_q <= lat_instr_d;
      lat_pc_q    <= lat_pc_d;
      lat_addr_q  <= lat_addr_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_rw_q    <= lat_rw_d;
      lat_ld_q    <= lat_ld_d;
      valid_q     <= valid_d;
      rw_q        <= rw_d;
      m2r_q       <= m2r_d;
      fault_q     <= fault_d;
      pc_src_q    <= pc_src_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      mem_data_q  <= mem_data_d;
      target_q    <= target_d;
    end
  end
  assign o_stall         = stall & i_rst_n;
  assign o_dmem_req      = req_q;
  assign o_dmem_we       = we_q;
  assign o_dmem_addr     = addr_q;
  assign o_dmem_wdata    = wdata_q;
  assign o_dmem_wstrb    = wstrb_q;
  assign o_pc_src        = pc_src_q;
  assign o_branch_target = target_q;
  assign o_valid         = valid_q;
  assign o_instruction   = instr_q;
  assign o_pc            = pc_q;
  assign o_alu_result    = alu_q;
  assign o_mem_data      = mem_data_q;
  assign o_rd            = instr_q[11:7];
  assign o_mem_to_reg    = m2r_q;
  assign o_reg_write     = rw_q;
  assign o_fault         = fault_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage with a directed upstream and bus responder
module tb_memory_stage;
  localparam int TMO = 16;
  localparam logic [6:0] OPC_OP = 7'h33, OPC_LD = 7'h03, OPC_ST = 7'h23, OPC_BR = 7'h63;
  localparam logic [5:0] C_OP = 6'b000001, C_LD = 6'b000111, C_ST = 6'b001000;
  localparam logic [5:0] C_BZ = 6'b110000, C_BN = 6'b100000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid, i_alu_zero, i_branch, i_mem_write, i_mem_read, i_mem_to_reg, i_reg_write;
  logic [31:0] i_instruction;
  logic [63:0] i_pc, i_alu_result, i_jmp_addr, i_rs2_value;
  logic o_stall, o_dmem_req, o_dmem_we, o_pc_src, o_valid, o_mem_to_reg, o_reg_write, o_fault;
  logic [63:0] o_dmem_addr, o_dmem_wdata, o_branch_target, o_pc, o_alu_result, o_mem_data;
  logic [7:0] o_dmem_wstrb;
  logic [31:0] o_instruction;
  logic [4:0] o_rd;
  logic dmem_ack = 1'b0;
  logic [63:0] dmem_rdata = '0;
  typedef struct { logic [63:0] pc, alu, mem; logic rw, fault; logic [4:0] rd; } wb_t;
  typedef struct { logic [63:0] addr, wdata; logic we; logic [7:0] wstrb; } bus_t;
  wb_t wb_q[$];
  bus_t bus_q[$];
  logic [63:0] br_q[$];
  int n_cmp = 0, n_bad = 0;
  int ack_wait = -1, req_cnt = 0, req_hi = 0;
  logic [63:0] rdata_v = '0;
  logic req_prev = 1'b0;

  memory_stage #(.XLEN(64), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc(i_pc), .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_jmp_addr(i_jmp_addr),
    .i_rs2_value(i_rs2_value), .i_branch(i_branch), .i_mem_write(i_mem_write),
    .i_mem_read(i_mem_read), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
    .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata), .o_pc_src(o_pc_src),
    .o_branch_target(o_branch_target), .o_valid(o_valid), .o_instruction(o_instruction),
    .o_pc(o_pc), .o_alu_result(o_alu_result), .o_mem_data(o_mem_data), .o_rd(o_rd),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_fault(o_fault));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {17'b0, f3, rd, opc};
  endfunction

  // Bus slave: acks the ack_wait-th cycle of a request (never when ack_wait < 0)
  always @(posedge clk) begin
    #1;
    if (o_dmem_req) begin
      dmem_ack   = (ack_wait >= 0) && (req_cnt == ack_wait);
      dmem_rdata = dmem_ack ? rdata_v : '0;
      req_cnt++;
      req_hi++;
    end else begin
      dmem_ack = 1'b0;
      req_cnt  = 0;
    end
  end

  // Monitor: pop and compare writeback, bus launch and redirect against the scoreboards
  always @(negedge clk) begin : mon
    wb_t e;
    bus_t b;
    if (o_valid) begin
      if (wb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wb_unexpected: got alu %h, no writeback expected", o_alu_result);
      end else begin
        e = wb_q.pop_front();
        chk("wb_pc", o_pc, e.pc);
        chk("wb_alu", o_alu_result, e.alu);
        chk("wb_mem_data", o_mem_data, e.mem);
        chk("wb_reg_write", 64'(o_reg_write), 64'(e.rw));
        chk("wb_fault", 64'(o_fault), 64'(e.fault));
        chk("wb_rd", 64'(o_rd), 64'(e.rd));
      end
    end
    if (o_fault) chk("fault_with_valid", 64'(o_valid), 64'd1);
    if (o_dmem_req && !req_prev) begin
      if (bus_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL bus_unexpected: got addr %h, no access expected", o_dmem_addr);
      end else begin
        b = bus_q.pop_front();
        chk("bus_addr", o_dmem_addr, b.addr);
        chk("bus_we", 64'(o_dmem_we), 64'(b.we));
        chk("bus_wstrb", 64'(o_dmem_wstrb), 64'(b.wstrb));
        chk("bus_wdata", o_dmem_wdata, b.wdata);
      end
    end
    req_prev = o_dmem_req;
    if (o_pc_src) begin
      if (br_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pc_src_unexpected: got target %h, no redirect expected", o_branch_target);
      end else chk("branch_target", o_branch_target, br_q.pop_front());
    end
  end

  task automatic bubble();
    i_valid = 0; i_alu_zero = 0; i_branch = 0; i_mem_write = 0; i_mem_read = 0;
    i_mem_to_reg = 0; i_reg_write = 0; i_instruction = '0; i_pc = '0; i_alu_result = '0;
    i_jmp_addr = '0; i_rs2_value = '0;
  endtask

  task automatic push_wb(input logic [63:0] pc, alu, mem, input logic rw, fault, input logic [4:0] rd);
    wb_t e;
    e.pc = pc; e.alu = alu; e.mem = mem; e.rw = rw; e.fault = fault; e.rd = rd;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic [63:0] addr, input logic we, input logic [7:0] strb, input logic [63:0] wdata);
    bus_t b;
    b.addr = addr; b.we = we; b.wstrb = strb; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  // Upstream model: hold the instruction while o_stall is high, then hand it over at the edge
  task automatic run(input logic [31:0] ins, input logic [63:0] pc, alu, rs2, jmp,
                     input logic [5:0] ctl, output int stalls);
    i_valid = 1; i_instruction = ins; i_pc = pc; i_alu_result = alu; i_rs2_value = rs2;
    i_jmp_addr = jmp; {i_branch, i_alu_zero, i_mem_write, i_mem_read, i_mem_to_reg, i_reg_write} = ctl;
    stalls = 0;
    @(negedge clk);
    while (o_stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (o_stall) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_bound: stall still high after %0d cycles", stalls);
    end
    @(posedge clk); #1;
    bubble();
  endtask

  task automatic ld(input string nm, input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] pc, addr,
                    rdata, input int w, input logic [63:0] exp_mem, input logic [7:0] strb, input int exp_st);
    int s;
    ack_wait = w; rdata_v = rdata;
    push_bus({addr[63:3], 3'b000}, 1'b0, strb, 64'd0);
    push_wb(pc, addr, exp_mem, 1'b1, 1'b0, rd);
    run(mk(f3, rd, OPC_LD), pc, addr, 64'd0, 64'd0, C_LD, s);
    chk({nm, "_stall"}, 64'(s), 64'(exp_st));
  endtask

  task automatic st(input string nm, input logic [2:0] f3, input logic [63:0] pc, addr, rs2, input int w,
                    input logic [7:0] strb, input logic [63:0] wdata, input int exp_st);
    int s;
    ack_wait = w;
    push_bus({addr[63:3], 3'b000}, 1'b1, strb, wdata);
    push_wb(pc, addr, 64'd0, 1'b0, 1'b0, 5'd0);
    run(mk(f3, 5'd0, OPC_ST), pc, addr, rs2, 64'd0, C_ST, s);
    chk({nm, "_stall"}, 64'(s), 64'(exp_st));
  endtask

  task automatic flt(input string nm, input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] pc, addr,
                     input logic [5:0] ctl);
    int s;
    push_wb(pc, addr, 64'd0, 1'b0, 1'b1, rd);
    run(mk(f3, rd, ctl[3] ? OPC_ST : OPC_LD), pc, addr, 64'h1234, 64'd0, ctl, s);
    chk({nm, "_stall"}, 64'(s), 64'd0);
  endtask

  initial begin
    int s;
    bubble();
    i_valid = 1; i_mem_read = 1; i_instruction = mk(3'b011, 5'd1, OPC_LD); i_alu_result = 64'h100;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_req", 64'(o_dmem_req), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_pc_src", 64'(o_pc_src), 64'd0);
    chk("rst_fault", 64'(o_fault), 64'd0);
    chk("rst_alu", o_alu_result, 64'd0);
    bubble();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    push_wb(64'h100, 64'h5, 64'd0, 1'b1, 1'b0, 5'd5);
    run(mk(3'b000, 5'd5, OPC_OP), 64'h100, 64'h5, 64'd0, 64'd0, C_OP, s);
    chk("add_stall", 64'(s), 64'd0);
    chk("add_next_valid", 64'(o_valid), 64'd1);
    chk("add_next_alu", o_alu_result, 64'h5);
    ld("lb", 3'b000, 5'd7, 64'h104, 64'h1003, 64'h1122_3344_8055_6677, 3, 64'hFFFF_FFFF_FFFF_FF80, 8'h08, 4);
    ld("lhu", 3'b101, 5'd8, 64'h108, 64'h1006, 64'hF00D_0000_0000_0000, 0, 64'h0000_0000_0000_F00D, 8'hC0, 1);
    ld("lw", 3'b010, 5'd9, 64'h10C, 64'h2004, 64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321, 8'hF0, 2);
    ld("ld", 3'b011, 5'd10, 64'h110, 64'h3000, 64'h0123_4567_89AB_CDEF, 2, 64'h0123_4567_89AB_CDEF, 8'hFF, 3);
    ld("lbu", 3'b100, 5'd11, 64'h114, 64'h3005, 64'h0000_9A00_0000_0000, 0, 64'h0000_0000_0000_009A, 8'h20, 1);
    ld("lh", 3'b001, 5'd12, 64'h118, 64'h3002, 64'h0000_0000_8001_0000, 0, 64'hFFFF_FFFF_FFFF_8001, 8'h0C, 1);
    st("sh", 3'b001, 64'h11C, 64'h2006, 64'hBEEF, 0, 8'hC0, 64'hBEEF_0000_0000_0000, 1);
    st("sb", 3'b000, 64'h120, 64'h11, 64'hFFAB, 0, 8'h02, 64'h0000_0000_00FF_AB00, 1);
    st("sw", 3'b010, 64'h124, 64'h14, 64'hDEAD_BEEF, 1, 8'hF0, 64'hDEAD_BEEF_0000_0000, 2);
    flt("lw_mis", 3'b010, 5'd13, 64'h128, 64'h1002, C_LD);
    flt("lh_mis", 3'b001, 5'd14, 64'h12C, 64'h1001, C_LD);
    flt("sd_mis", 3'b011, 5'd0, 64'h130, 64'h2004, C_ST);
    flt("f3_111", 3'b111, 5'd15, 64'h134, 64'h1000, C_LD);
    push_wb(64'h138, 64'h77, 64'd0, 1'b1, 1'b0, 5'd6);
    run(mk(3'b000, 5'd6, OPC_OP), 64'h138, 64'h77, 64'd0, 64'd0, C_OP, s);
    req_hi = 0;
    ack_wait = -1;
    push_bus(64'h4000, 1'b0, 8'hFF, 64'd0);
    push_wb(64'h13C, 64'h4000, 64'd0, 1'b0, 1'b1, 5'd16);
    run(mk(3'b011, 5'd16, OPC_LD), 64'h13C, 64'h4000, 64'd0, 64'd0, C_LD, s);
    chk("timeout_stall", 64'(s), 64'(TMO));
    chk("timeout_req_cycles", 64'(req_hi), 64'(TMO));
    chk("timeout_req_dropped", 64'(o_dmem_req), 64'd0);
    br_q.push_back(64'h400);
    push_wb(64'h200, 64'd0, 64'd0, 1'b0, 1'b0, 5'd0);
    run(mk(3'b000, 5'd0, OPC_BR), 64'h200, 64'd0, 64'd0, 64'h400, C_BZ, s);
    chk("beq_stall", 64'(s), 64'd0);
    push_wb(64'h204, 64'h3, 64'd0, 1'b0, 1'b0, 5'd0);
    run(mk(3'b000, 5'd0, OPC_BR), 64'h204, 64'h3, 64'd0, 64'h800, C_BN, s);
    ack_wait = -1;
    push_bus(64'h5000, 1'b0, 8'hFF, 64'd0);
    i_valid = 1; i_mem_read = 1; i_mem_to_reg = 1; i_reg_write = 1;
    i_instruction = mk(3'b011, 5'd17, OPC_LD); i_alu_result = 64'h5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_req_before_rst", 64'(o_dmem_req), 64'd1);
    rst_n = 0;
    #1;
    chk("rst_in_wait_req", 64'(o_dmem_req), 64'd0);
    chk("rst_in_wait_stall", 64'(o_stall), 64'd0);
    bubble();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    push_wb(64'h300, 64'h9, 64'd0, 1'b1, 1'b0, 5'd3);
    run(mk(3'b000, 5'd3, OPC_OP), 64'h300, 64'h9, 64'd0, 64'd0, C_OP, s);
    chk("post_rst_stall", 64'(s), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    chk("br_queue_drained", 64'(br_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
